pipelined_barrel_shifter: RTL

Parametrised, pipelined, multi-mode barrel shifter. It is the successor to the 8-bit, 3-level, combinational logical-right shifter built from 2:1 mux levels. It generalises width, adds left/arithmetic/rotate modes, registers every mux level, and wraps the datapath in a valid/ready handshake so it can sit between streaming ALU/DSP stages.

---
 rtl/pipelined_barrel_shifter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter
//   Multi-mode barrel shifter built from log2(WIDTH) registered mux levels.
//   Stage k shifts by 2^(SHW-1-k) when its amount bit is set, so the largest
//   shift happens first. The shift amount, mode and original sign bit travel
//   down the pipe with each word. A single global advance signal moves or
//   holds the whole pipe, which gives a simple valid/ready stream interface.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (clears every stage)
//   in_valid   operand valid
//   in_ready   pipe can accept an operand this cycle
//   in_data    operand, WIDTH bits
//   in_amt     shift amount, SHW bits
//   in_mode    00 logical right, 01 logical left, 10 arithmetic right,
//              11 rotate right
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   shifted result
//   out_zero   out_data is all zeros
module pipelined_barrel_shifter #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_LSL = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  localparam logic [WIDTH-1:0] ONES = '1;

  logic adv;

  // The pipe moves whenever the output slot is empty or being drained, so
  // bubbles inside the pipe are squeezed forward while nothing is waiting.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  for (genvar k = 0; k < SHW; k++) begin : gStage
    localparam int BIT = SHW - 1 - k;
    localparam int SH  = 1 << BIT;

    logic             validIn;
    logic [WIDTH-1:0] dataIn;
    logic [SHW-1:0]   amtIn;
    logic [1:0]       modeIn;
    logic             signIn;

    logic [WIDTH-1:0] data_d;

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   amt_q;
    logic [1:0]       mode_q;
    logic             sign_q;

    if (k == 0) begin : gFirst
      // The sign is captured here from the untouched operand so arithmetic
      // fill never depends on what earlier levels did to the MSB.
      assign validIn = in_valid;
      assign dataIn  = in_data;
      assign amtIn   = in_amt;
      assign modeIn  = in_mode;
      assign signIn  = in_data[WIDTH-1];
    end else begin : gNext
      assign validIn = gStage[k-1].valid_q;
      assign dataIn  = gStage[k-1].data_q;
      assign amtIn   = gStage[k-1].amt_q;
      assign modeIn  = gStage[k-1].mode_q;
      assign signIn  = gStage[k-1].sign_q;
    end

    // One mux level: shift by this stage's fixed distance or pass through.
    always_comb begin
      data_d = dataIn;
      if (amtIn[BIT]) begin
        case (modeIn)
          MODE_LSR: data_d = dataIn >> SH;
          MODE_LSL: data_d = dataIn << SH;
          MODE_ASR: data_d = (dataIn >> SH) | (signIn ? ~(ONES >> SH) : '0);
          MODE_ROR: data_d = (dataIn >> SH) | (dataIn << (WIDTH - SH));
          default:  data_d = dataIn >> SH;
        endcase
      end
    end

    // Stage register: loads from its predecessor on advance, otherwise holds.
    // The data fields update even for bubbles; only valid_q is meaningful.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        amt_q   <= '0;
        mode_q  <= '0;
        sign_q  <= 1'b0;
      end else if (adv) begin
        valid_q <= validIn;
        data_q  <= data_d;
        amt_q   <= amtIn;
        mode_q  <= modeIn;
        sign_q  <= signIn;
      end
    end
  end

  assign out_valid = gStage[SHW-1].valid_q;
  assign out_data  = gStage[SHW-1].data_q;
  assign out_zero  = (gStage[SHW-1].data_q == '0);

  // The control fields of the last stage have no consumer downstream.
  logic unusedTail;
  assign unusedTail = ^{gStage[SHW-1].amt_q, gStage[SHW-1].mode_q,
                        gStage[SHW-1].sign_q};

endmodule
